// File: rtl/bus_message_endpoint.sv
// Bus-side endpoint: stamps and queues core sends toward the network, loops
// self-addressed sends back to the core, and filters network arrivals into the core queue.

module bus_message_endpoint_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         push_ok, pop_ok;

  // The extra pointer bit separates a full queue from an empty one.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign push_ok = push_i & ~full_o & ~clear_i;
  assign pop_ok  = pop_i & ~empty_o & ~clear_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_ONE;
      if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end
endmodule

module bus_message_endpoint #(
  parameter logic [31:0] NODE_ID  = 32'd0,
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        core_val_i,
  output logic        core_ack_o,
  input  logic [31:0] core_dst_i,
  input  logic [31:0] core_tag_i,
  input  logic [63:0] core_msg_i,
  output logic        core_val_o,
  input  logic        core_rdy_i,
  output logic [31:0] core_src_o,
  output logic [31:0] core_tag_o,
  output logic [63:0] core_msg_o,
  output logic        net_tx_val_o,
  input  logic        net_tx_rdy_i,
  output logic [31:0] net_tx_dst_o,
  output logic [31:0] net_tx_src_o,
  output logic [31:0] net_tx_tag_o,
  output logic [63:0] net_tx_msg_o,
  input  logic        net_rx_val_i,
  output logic        net_rx_rdy_o,
  input  logic [31:0] net_rx_dst_i,
  input  logic [31:0] net_rx_src_i,
  input  logic [31:0] net_rx_tag_i,
  input  logic [63:0] net_rx_msg_i,
  output logic [15:0] drop_count_o
);
  localparam int TXW = 160;
  localparam int RXW = 128;

  // Valid/ready convention on every channel: a transfer happens in a cycle where
  // the sender's val and the receiver's rdy/ack are both high at the clock edge.
  logic           active;
  logic           core_is_local, local_cand;
  logic           net_match, net_cand, contention;
  logic           local_grant, net_grant;
  logic           remote_ack, local_ack;
  logic           net_acc, net_drop;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [TXW-1:0] tx_wdata, tx_head;
  logic [RXW-1:0] rx_wdata, rx_head;
  logic           last_local_q, last_local_d;
  logic [15:0]    drop_count_q, drop_count_d;

  assign active        = rst_n & ~flush;
  assign core_is_local = (core_dst_i == NODE_ID);
  assign local_cand    = core_val_i & core_is_local;
  assign net_match     = (net_rx_dst_i == NODE_ID);
  assign net_cand      = net_rx_val_i & net_match;
  assign contention    = local_cand & net_cand;

  // Round-robin only matters under contention; a lone requester always wins.
  assign local_grant = ~net_cand | ~last_local_q;
  assign net_grant   = ~local_cand | (net_cand & last_local_q);

  assign remote_ack = active & core_val_i & ~core_is_local & ~tx_full;
  assign local_ack  = active & local_cand & local_grant & ~rx_full;
  assign core_ack_o = remote_ack | local_ack;

  assign net_rx_rdy_o = active & (net_match ? (~rx_full & net_grant) : 1'b1);
  assign net_acc      = net_rx_val_i & net_rx_rdy_o & net_match;
  assign net_drop     = net_rx_val_i & net_rx_rdy_o & ~net_match;

  assign tx_push  = remote_ack;
  assign tx_wdata = {core_dst_i, NODE_ID, core_tag_i, core_msg_i};

  // The arbiter never grants both writers at once, so a simple select suffices.
  assign rx_push  = local_ack | net_acc;
  assign rx_wdata = local_ack ? {NODE_ID, core_tag_i, core_msg_i}
                              : {net_rx_src_i, net_rx_tag_i, net_rx_msg_i};

  assign core_val_o   = active & ~rx_empty;
  assign rx_pop       = core_val_o & core_rdy_i;
  assign net_tx_val_o = active & ~tx_empty;
  assign tx_pop       = net_tx_val_o & net_tx_rdy_i;

  assign {core_src_o, core_tag_o, core_msg_o}                 = rx_head;
  assign {net_tx_dst_o, net_tx_src_o, net_tx_tag_o, net_tx_msg_o} = tx_head;
  assign drop_count_o = drop_count_q;

  always_comb begin
    last_local_d = last_local_q;
    if (flush) begin
      last_local_d = 1'b0;
    end else if (contention && !rx_full) begin
      last_local_d = local_ack;
    end
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (net_drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_local_q <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      last_local_q <= last_local_d;
      drop_count_q <= drop_count_d;
    end
  end

  bus_message_endpoint_fifo #(.W(TXW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (tx_push),
    .wdata_i (tx_wdata),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  bus_message_endpoint_fifo #(.W(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (rx_push),
    .wdata_i (rx_wdata),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );
endmodule

// File: tb/tb_bus_message_endpoint.sv
// Self-checking bench for bus_message_endpoint: directed scenarios plus random
// traffic against a queue-based reference model of the endpoint's rules.

module tb_bus_message_endpoint;
  localparam logic [31:0] NODE_ID  = 32'd5;
  localparam int          TX_DEPTH = 4;
  localparam int          RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        core_val_i;
  logic        core_ack_o;
  logic [31:0] core_dst_i, core_tag_i;
  logic [63:0] core_msg_i;
  logic        core_val_o;
  logic        core_rdy_i;
  logic [31:0] core_src_o, core_tag_o;
  logic [63:0] core_msg_o;
  logic        net_tx_val_o;
  logic        net_tx_rdy_i;
  logic [31:0] net_tx_dst_o, net_tx_src_o, net_tx_tag_o;
  logic [63:0] net_tx_msg_o;
  logic        net_rx_val_i;
  logic        net_rx_rdy_o;
  logic [31:0] net_rx_dst_i, net_rx_src_i, net_rx_tag_i;
  logic [63:0] net_rx_msg_i;
  logic [15:0] drop_count_o;

  bus_message_endpoint #(.NODE_ID(NODE_ID), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .core_val_i (core_val_i), .core_ack_o (core_ack_o),
    .core_dst_i (core_dst_i), .core_tag_i (core_tag_i), .core_msg_i (core_msg_i),
    .core_val_o (core_val_o), .core_rdy_i (core_rdy_i),
    .core_src_o (core_src_o), .core_tag_o (core_tag_o), .core_msg_o (core_msg_o),
    .net_tx_val_o (net_tx_val_o), .net_tx_rdy_i (net_tx_rdy_i),
    .net_tx_dst_o (net_tx_dst_o), .net_tx_src_o (net_tx_src_o),
    .net_tx_tag_o (net_tx_tag_o), .net_tx_msg_o (net_tx_msg_o),
    .net_rx_val_i (net_rx_val_i), .net_rx_rdy_o (net_rx_rdy_o),
    .net_rx_dst_i (net_rx_dst_i), .net_rx_src_i (net_rx_src_i),
    .net_rx_tag_i (net_rx_tag_i), .net_rx_msg_i (net_rx_msg_i),
    .drop_count_o (drop_count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [159:0] tx_exp_q[$];
  logic [127:0] rx_exp_q[$];
  bit           m_last_local;
  int unsigned  m_drop;
  logic         obs_ack, obs_rdy;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_exp_q.delete();
    rx_exp_q.delete();
    m_last_local = 1'b0;
    m_drop       = 0;
  endtask

  task automatic check_reset_outputs(input string ph);
    check_eq({ph, "_ack"},     core_ack_o,   0);
    check_eq({ph, "_cval"},    core_val_o,   0);
    check_eq({ph, "_txval"},   net_tx_val_o, 0);
    check_eq({ph, "_rxrdy"},   net_rx_rdy_o, 0);
    check_eq({ph, "_drop"},    drop_count_o, 0);
    check_eq({ph, "_coredat"}, {core_src_o, core_tag_o, core_msg_o}, 0);
    check_eq({ph, "_txdat"},   {net_tx_dst_o, net_tx_src_o, net_tx_tag_o, net_tx_msg_o}, 0);
  endtask

  // One clock cycle: compare outputs against the model at the falling edge,
  // then advance the model with the transfers that the rules say happen.
  task automatic cycle();
    bit txf, rxf, loc, rem, nm, lwin, e_ack, e_rdy, e_cval, e_tval;
    @(negedge clk);
    txf   = (tx_exp_q.size() == TX_DEPTH);
    rxf   = (rx_exp_q.size() == RX_DEPTH);
    loc   = core_val_i && (core_dst_i == NODE_ID);
    rem   = core_val_i && (core_dst_i != NODE_ID);
    nm    = net_rx_val_i && (net_rx_dst_i == NODE_ID);
    lwin  = loc && (!nm || !m_last_local);
    e_ack = !flush && ((rem && !txf) || (lwin && !rxf));
    if (net_rx_dst_i != NODE_ID) e_rdy = !flush;
    else e_rdy = !flush && !rxf && (!loc || (nm && m_last_local));
    e_cval = !flush && (rx_exp_q.size() > 0);
    e_tval = !flush && (tx_exp_q.size() > 0);
    check_eq("core_ack", core_ack_o, e_ack);
    check_eq("net_rx_rdy", net_rx_rdy_o, e_rdy);
    check_eq("core_val", core_val_o, e_cval);
    check_eq("net_tx_val", net_tx_val_o, e_tval);
    check_eq("drop_count", drop_count_o, 16'(m_drop));
    if (e_cval) check_eq("core_head", {core_src_o, core_tag_o, core_msg_o}, rx_exp_q[0]);
    if (e_tval) check_eq("tx_head", {net_tx_dst_o, net_tx_src_o, net_tx_tag_o, net_tx_msg_o}, tx_exp_q[0]);
    obs_ack = core_ack_o;
    obs_rdy = net_rx_rdy_o;
    @(posedge clk);
    if (flush) begin
      tx_exp_q.delete();
      rx_exp_q.delete();
      m_last_local = 1'b0;
    end else begin
      if (e_cval && core_rdy_i)   void'(rx_exp_q.pop_front());
      if (e_tval && net_tx_rdy_i) void'(tx_exp_q.pop_front());
      if (e_ack && rem) tx_exp_q.push_back({core_dst_i, NODE_ID, core_tag_i, core_msg_i});
      if (e_ack && loc) rx_exp_q.push_back({NODE_ID, core_tag_i, core_msg_i});
      if (nm && e_rdy)  rx_exp_q.push_back({net_rx_src_i, net_rx_tag_i, net_rx_msg_i});
      if (net_rx_val_i && (net_rx_dst_i != NODE_ID) && e_rdy && (m_drop != 32'hFFFF)) m_drop++;
      if (loc && nm && !rxf) m_last_local = lwin;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush        = 1'b0;
    core_val_i   = 1'b0;
    core_dst_i   = '0;
    core_tag_i   = '0;
    core_msg_i   = '0;
    core_rdy_i   = 1'b0;
    net_tx_rdy_i = 1'b0;
    net_rx_val_i = 1'b0;
    net_rx_dst_i = '0;
    net_rx_src_i = '0;
    net_rx_tag_i = '0;
    net_rx_msg_i = '0;
  endtask

  task automatic drive_core(input logic [31:0] dst, input logic [31:0] tag, input logic [63:0] msg);
    core_val_i = 1'b1;
    core_dst_i = dst;
    core_tag_i = tag;
    core_msg_i = msg;
  endtask

  task automatic drive_net(input logic [31:0] dst, input logic [31:0] src,
                           input logic [31:0] tag, input logic [63:0] msg);
    net_rx_val_i = 1'b1;
    net_rx_dst_i = dst;
    net_rx_src_i = src;
    net_rx_tag_i = tag;
    net_rx_msg_i = msg;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acks, sent, k;
    drive_idle();
    rst_n = 1'b0;
    drive_core(32'd9, 32'd1, 64'h1);
    drive_net(32'd7, 32'd2, 32'd2, 64'h2);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    drive_idle();
    model_reset();

    // Remote send: ack in the same cycle, header visible the next cycle.
    drive_core(32'd9, 32'd3, 64'hA5);
    cycle();
    check_eq("remote_ack", obs_ack, 1);
    core_val_i = 1'b0;
    check_eq("remote_hdr", {net_tx_val_o, net_tx_dst_o, net_tx_src_o, net_tx_tag_o, net_tx_msg_o},
             {1'b1, 32'd9, 32'd5, 32'd3, 64'hA5});
    net_tx_rdy_i = 1'b1;
    cycle();
    net_tx_rdy_i = 1'b0;

    // TX backpressure: six sends into a four-deep queue that is not draining.
    acks = 0;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      drive_core(32'd12, 32'(100 + sent), {32'hBEEF0000, 32'(sent)});
      cycle();
      if (obs_ack) begin acks++; sent++; end
    end
    check_eq("bp_ack_count", acks, 4);
    net_tx_rdy_i = 1'b1;
    for (int c = 0; c < 20 && sent < 6; c++) begin
      drive_core(32'd12, 32'(100 + sent), {32'hBEEF0000, 32'(sent)});
      cycle();
      if (obs_ack) sent++;
    end
    check_eq("bp_all_sent", sent, 6);
    core_val_i = 1'b0;
    repeat (6) cycle();
    net_tx_rdy_i = 1'b0;

    // Filtering: three misaddressed, one addressed.
    for (int i = 0; i < 4; i++) begin
      drive_net((i < 3) ? 32'd7 : NODE_ID, 32'd40 + 32'(i), 32'd50 + 32'(i), 64'hC0DE_0000 + 64'(i));
      cycle();
      check_eq("filter_accept", obs_rdy, 1);
    end
    net_rx_val_i = 1'b0;
    check_eq("filter_drops", drop_count_o, 16'd3);
    check_eq("filter_head", {core_val_o, core_src_o, core_tag_o, core_msg_o},
             {1'b1, 32'd43, 32'd53, 64'hC0DE_0003});
    core_rdy_i = 1'b1;
    cycle();
    check_eq("filter_only_one", core_val_o, 0);
    core_rdy_i = 1'b0;

    // Flush with two TX and three RX entries pending.
    for (int i = 0; i < 2; i++) begin
      drive_core(32'd20, 32'(i), 64'(i));
      cycle();
    end
    core_val_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_net(NODE_ID, 32'd60, 32'(i), 64'(i));
      cycle();
    end
    net_rx_val_i = 1'b0;
    flush = 1'b1;
    #1;
    check_eq("flush_vals", {core_val_o, net_tx_val_o, core_ack_o}, 3'b000);
    cycle();
    flush = 1'b0;
    check_eq("flush_after", {core_val_o, net_tx_val_o}, 2'b00);
    check_eq("flush_drop_kept", drop_count_o, 16'd3);
    cycle();

    // Asynchronous reset in the middle of a stream.
    net_tx_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_core(32'd30, 32'(i), 64'h77 + 64'(i));
      drive_net(NODE_ID, 32'd31, 32'(i), 64'h88 + 64'(i));
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_idle();
    net_tx_rdy_i = 1'b0;
    drive_core(32'd9, 32'd44, 64'h4444);
    cycle();
    core_val_i = 1'b0;
    check_eq("rst_first_push", {net_tx_val_o, net_tx_dst_o, net_tx_src_o}, {1'b1, 32'd9, NODE_ID});
    net_tx_rdy_i = 1'b1;
    cycle();
    net_tx_rdy_i = 1'b0;

    // Arbitration: both writers request continuously; local wins first.
    core_rdy_i = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      drive_core(NODE_ID, 32'(200 + i), 64'(i));
      drive_net(NODE_ID, 32'd9, 32'(300 + i), 64'(i));
      cycle();
      check_eq("arb_local_turn", obs_ack, (i % 2) == 0);
      check_eq("arb_net_turn", obs_rdy, (i % 2) == 1);
    end
    drive_idle();
    repeat (3) cycle();

    // Random traffic, protocol-correct: each side holds its message until taken.
    for (int c = 0; c < 1500; c++) begin
      if (!core_val_i || obs_ack) begin
        core_val_i = ($urandom_range(0, 3) != 0);
        core_dst_i = ($urandom_range(0, 2) == 0) ? NODE_ID : 32'($urandom_range(0, 15));
        core_tag_i = $urandom();
        core_msg_i = {$urandom(), $urandom()};
      end
      if (!net_rx_val_i || obs_rdy) begin
        net_rx_val_i = ($urandom_range(0, 2) != 0);
        net_rx_dst_i = ($urandom_range(0, 1) == 0) ? NODE_ID : 32'($urandom_range(0, 15));
        net_rx_src_i = $urandom();
        net_rx_tag_i = $urandom();
        net_rx_msg_i = {$urandom(), $urandom()};
      end
      core_rdy_i   = ($urandom_range(0, 3) != 0);
      net_tx_rdy_i = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 63) == 0);
      cycle();
    end

    // Drop counter saturation under a long flood of misaddressed traffic.
    drive_idle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive_net(32'd7, 32'd1, 32'd1, 64'd1);
    repeat (65540) @(posedge clk);
    #1;
    m_drop = (m_drop + 65540 > 32'hFFFF) ? 32'hFFFF : m_drop + 65540;
    cycle();
    cycle();
    check_eq("drop_saturated", drop_count_o, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
